// File: rtl/btn_event_arbiter_if.sv
// Handshake bundle between the button shapers, the event arbiter and its consumer.
// The master drives the press pulses, flush and ack; the slave (the arbiter) drives the event outputs.
interface btn_event_arbiter_if #(
  parameter int IDW = 2,
  parameter int AW  = 2
);
  logic [2**IDW-1:0] pulse_in;
  logic              flush;
  logic              ev_ack;
  logic              ev_valid;
  logic [IDW-1:0]    ev_id;
  logic [AW:0]       count;
  logic [2**IDW-1:0] pend;
  logic              drop;

  modport master (
    output pulse_in, flush, ev_ack,
    input  ev_valid, ev_id, count, pend, drop
  );

  modport slave (
    input  pulse_in, flush, ev_ack,
    output ev_valid, ev_id, count, pend, drop
  );
endinterface

// File: rtl/btn_event_arbiter.sv
// Latches one-cycle button presses as pending requests and serializes them, one per cycle,
// into a small event FIFO using round-robin arbitration starting after the last granted source.
module btn_event_arbiter #(
  parameter int IDW = 2,
  parameter int AW  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  btn_event_arbiter_if.slave   bus
);
  localparam int N = 1 << IDW;
  localparam int D = 1 << AW;

  logic [N-1:0]   pend_q, pend_d;
  logic [IDW-1:0] last_q, last_d;
  logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           drop_q, drop_d;
  logic [IDW-1:0] mem_q [D];

  logic           full;
  logic           push;
  logic           pop;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   gmask;

  assign full = (cnt_q == (AW+1)'(D));
  assign pop  = bus.ev_ack && (cnt_q != '0);

  // Scan pending bits starting one past the last grant; the final step lands back on last_q.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    found    = 1'b0;
    grant_id = last_q;
    idx      = last_q;
    for (int k = 1; k <= N; k++) begin
      idx = last_q + IDW'(k);
      if (!found && pend_q[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    push  = found && !full && !bus.flush;
    gmask = push ? ({{(N-1){1'b0}}, 1'b1} << grant_id) : '0;
  end

  always_comb begin
    pend_d = pend_q;
    last_d = last_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (bus.flush) begin
      pend_d = '0;
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
    end else begin
      // A pulse on a bit that stays pending is coalesced; a pulse on the granted bit is a fresh request.
      pend_d = (pend_q & ~gmask) | bus.pulse_in;
      if (|(bus.pulse_in & pend_q & ~gmask)) drop_d = 1'b1;
      if (push) begin
        wr_d   = wr_q + 1'b1;
        last_d = grant_id;
      end
      if (pop) rd_d = rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pend_q <= '0;
      last_q <= IDW'(N - 1);
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  // Storage holds only IDs; occupancy is tracked by cnt_q, so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (RST && push) mem_q[wr_q] <= grant_id;
  end

  assign bus.ev_valid = (cnt_q != '0);
  assign bus.ev_id    = bus.ev_valid ? mem_q[rd_q] : '0;
  assign bus.count    = cnt_q;
  assign bus.pend     = pend_q;
  assign bus.drop     = drop_q;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Randomized and directed bench for btn_event_arbiter, checked each cycle against a queue-based model.
module tb_btn_event_arbiter;
  localparam int IDW = 2;
  localparam int AW  = 2;
  localparam int N   = 1 << IDW;
  localparam int D   = 1 << AW;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   total = 0;
  int   bad   = 0;

  btn_event_arbiter_if #(.IDW(IDW), .AW(AW)) bus ();

  btn_event_arbiter #(.IDW(IDW), .AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Reference state: FIFO contents as a queue of IDs plus the pending set.
  int       q[$];
  bit [N-1:0] m_pend = '0;
  int       m_last = N - 1;
  bit       m_drop = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    int pre;
    bit [N-1:0] pb;
    if (!RST) begin
      q.delete();
      m_pend = '0;
      m_last = N - 1;
      m_drop = 1'b0;
    end else if (bus.flush) begin
      q.delete();
      m_pend = '0;
    end else begin
      g   = -1;
      pre = q.size();
      pb  = m_pend;
      if (m_pend != 0 && pre < D)
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (g < 0 && m_pend[idx]) g = idx;
        end
      if (bus.ev_ack && pre > 0) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back(g);
        m_pend[g] = 1'b0;
        m_last    = g;
      end
      for (int i = 0; i < N; i++)
        if (bus.pulse_in[i]) begin
          if (pb[i] && i != g) m_drop = 1'b1;
          m_pend[i] = 1'b1;
        end
    end
  endtask

  task automatic compare();
    check("count", int'(bus.count), q.size());
    check("ev_valid", int'(bus.ev_valid), (q.size() != 0) ? 1 : 0);
    check("ev_id", int'(bus.ev_id), (q.size() != 0) ? q[0] : 0);
    check("pend", int'(bus.pend), int'(m_pend));
    check("drop", int'(bus.drop), int'(m_drop));
  endtask

  always @(posedge CLK) begin
    model_step();
    #1;
    compare();
  end

  task automatic step(input logic [N-1:0] p, input logic f, input logic a, input logic r);
    bus.pulse_in = p;
    bus.flush    = f;
    bus.ev_ack   = a;
    RST          = r;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    bus.pulse_in = '0;
    bus.flush    = 1'b0;
    bus.ev_ack   = 1'b0;

    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst_count", int'(bus.count), 0);
    check("rst_valid", int'(bus.ev_valid), 0);

    // Single press: two-cycle latency, then pop.
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    check("single_pend", int'(bus.pend), 1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    check("single_valid", int'(bus.ev_valid), 1);
    check("single_id", int'(bus.ev_id), 0);
    check("single_count", int'(bus.count), 1);
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    check("single_pop", int'(bus.ev_valid), 0);

    // All four at once after reset: IDs 0..3 queued in order.
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b0, 1'b1);
    check("all_count", int'(bus.count), 4);
    check("all_head", int'(bus.ev_id), 0);
    check("all_drop", int'(bus.drop), 0);

    // Full: new presses latch, repeated press coalesces into drop.
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    check("full_pend", int'(bus.pend), 4'b0100);
    check("full_count", int'(bus.count), 4);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    check("full_drop", int'(bus.drop), 1);
    check("full_pend2", int'(bus.pend), 4'b0110);
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    check("pop_at_full_count", int'(bus.count), 3);
    check("pop_at_full_pend", int'(bus.pend), 4'b0110);

    // Flush mid-operation keeps drop; reset with flush clears it.
    step(4'b0001, 1'b1, 1'b0, 1'b1);
    check("flush_count", int'(bus.count), 0);
    check("flush_pend", int'(bus.pend), 0);
    check("flush_drop", int'(bus.drop), 1);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    check("rstflush_drop", int'(bus.drop), 0);

    // Press on the grant cycle re-arms without drop.
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    check("regrant_pend", int'(bus.pend), 1);
    check("regrant_drop", int'(bus.drop), 0);
    check("regrant_count", int'(bus.count), 1);

    // Round robin with last_grant=1: 0101 grants 2 then 0.
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    check("rr_first", int'(bus.ev_id), 1);
    step(4'b0101, 1'b0, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    check("rr_second", int'(bus.ev_id), 2);
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    check("rr_third", int'(bus.ev_id), 0);
    check("rr_count", int'(bus.count), 1);

    // Random traffic, with ack density varying to exercise both empty and full.
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] p;
      logic f, a, r;
      p = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      f = ($urandom_range(0, 80) == 0);
      if ((c / 500) % 2 == 0) a = ($urandom_range(0, 3) == 0);
      else                    a = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 400) != 0);
      step(p, f, a, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Collects one-cycle press pulses from several button shapers, latches them as pending requests, and serializes them into a small FIFO using round-robin arbitration. A single consumer (the login or game controller) drains the FIFO over a valid/ack handshake. The block sits between the per-button shapers and the mode controllers, so that no press is lost when two buttons fire in the same cycle or while the consumer is busy.

## Interface
- IDW, 2: source ID width; number of sources N = 2**IDW.
- AW, 2: FIFO address width; depth D = 2**AW.
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset; synchronous, active-low.
- pulse_in  in  N  one-cycle press pulses, bit i from shaper i; active high.
- flush  in  1  synchronous clear of pending bits and FIFO, for example on a mode change; active high.
- ev_ack  in  1  consumer pops the head entry; honoured only when ev_valid=1.
- ev_valid  out  1  FIFO non-empty.
- ev_id  out  IDW  ID of the source at the FIFO head; valid when ev_valid=1.
- count  out  AW+1  FIFO occupancy, 0..D.
- pend  out  N  pending-request register, for debug.
- drop  out  1  sticky flag: set when a press was coalesced into an already-pending request.

## Operation
- Reset (RST=0 at an edge): pend=0, FIFO empty (count=0, rd_ptr=wr_ptr=0), ev_valid=0, ev_id=0, drop=0, last_grant=N-1. Reset overrides flush and every other input.
- Pending latch: pend[i] is set at the edge where pulse_in[i]=1.
  - If pend[i] was already 1 and is not granted this cycle, drop is set; the request stays single.
- Grant: each cycle with pend!=0 and count<D, exactly one source is granted.
  - Search order: ascending from (last_grant+1) mod N, wrapping around.
  - The grant writes the granted ID at wr_ptr, clears that pend bit, and sets last_grant to the granted ID.
  - If pulse_in[g]=1 in the same cycle that g is granted, pend[g] stays 1. This is a new request, not a drop.
- Full: when count=D there is no grant, pend bits hold, and new pulses still latch.
  - No push occurs even if ev_ack pops in the same cycle; the push is evaluated on pre-pop count.
- Pop: ev_ack=1 with ev_valid=1 advances rd_ptr. ev_ack with ev_valid=0 is ignored; nothing changes.
- Simultaneous push and pop (0<count<D): count is unchanged and both pointers advance.
- Pointers wrap modulo D. count is tracked explicitly, so full and empty are unambiguous.
- Flush: at the edge, pend=0 and the FIFO empties (count=0, pointers=0). Pulses in the flush cycle are discarded. last_grant and drop are preserved.
- ev_id is driven from the head entry combinationally; its value while ev_valid=0 is don't-care.

## Timing
- Pulse sampled at edge k: pend set after k, granted at edge k+1, ev_valid=1 after k+1. Latency is 2 cycles when the FIFO has room and there are no competing requests.
- N simultaneous pulses at edge k produce N pushes at edges k+1..k+N, one per cycle, in round-robin order.
- Pop at edge m: the next entry appears after m; back-to-back pops sustain 1 event/cycle.
- When a pop frees a slot at edge m while count was D, the first grant happens at edge m+1.
- All outputs are registered or derived directly from registers (ev_id via head-entry read). There is no combinational path from inputs to outputs.

## Test plan
- Single press: pulse_in=0001 at edge 1, ev_ack held 0 -> ev_valid=1, ev_id=0, count=1 after edge 2; ev_ack=1 -> ev_valid=0 after the next edge.
- Simultaneous presses: pulse_in=1111 at one edge after reset -> FIFO receives IDs 0,1,2,3 on consecutive edges; count reaches 4; drop=0.
- Round-robin fairness: with last_grant=1, assert pulse_in=0101 -> grant order 2 then 0. Repeat 1111 twice and drain in between -> each source is granted once per round.
- Full/backpressure: fill to D=4 with no acks, then pulse source 2 -> pend[2]=1, count stays 4. One ack -> source 2 is pushed one cycle later and count returns to 4.
- Coalesce/drop: pulse source 1 twice while the FIFO is full -> a single pending request, drop=1 and sticky. Pulse on the exact grant cycle -> pend stays 1 and drop is unchanged.
- Flush and reset mid-operation: count=3, pend=0110, flush=1 -> count=0, pend=0, ev_valid=0, drop preserved. Then RST=0 with flush=1 -> all outputs zero and drop=0.
